// File: rtl/comp_fprint_buffer_if.sv
// rtl/comp_fprint_buffer_if.sv - comparator <-> fingerprint buffer handshake and read-back bundle
interface comp_fprint_buffer_if #(
  parameter int CRC_KEY_WIDTH = 4,
  parameter int CRC_WIDTH     = 32
);
  logic [CRC_KEY_WIDTH-1:0] comp_task;
  logic                     comp_increment_tail_pointer;
  logic                     comp_reset_fprint_ready;
  logic                     reset_fprint_ack;
  logic                     comp_task_verified;
  logic                     fprint_reg_ack;
  logic                     comp_reset_task;
  logic                     reset_task_ack;
  logic                     comp_status_write;
  logic                     comp_status_ack;
  logic                     comp_mismatch_detected;
  logic [CRC_WIDTH-1:0]     fprint0;
  logic [CRC_WIDTH-1:0]     fprint1;
  logic                     head0_matches_head1;
  logic                     tail0_matches_head0;
  logic                     tail1_matches_head1;

  modport master (
    output comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready,
           comp_task_verified, comp_reset_task, comp_status_write, comp_mismatch_detected,
    input  reset_fprint_ack, fprint_reg_ack, reset_task_ack, comp_status_ack,
           fprint0, fprint1, head0_matches_head1, tail0_matches_head0, tail1_matches_head1
  );

  modport slave (
    input  comp_task, comp_increment_tail_pointer, comp_reset_fprint_ready,
           comp_task_verified, comp_reset_task, comp_status_write, comp_mismatch_detected,
    output reset_fprint_ack, fprint_reg_ack, reset_task_ack, comp_status_ack,
           fprint0, fprint1, head0_matches_head1, tail0_matches_head0, tail1_matches_head1
  );
endinterface

// File: rtl/comp_fprint_buffer.sv
// rtl/comp_fprint_buffer.sv - per-task, per-core fingerprint ring buffers answering the comparator handshakes
// Optional feature macro: COMP_BUF_OVERFLOW_EN (sticky per-core overflow flags).
module comp_fprint_buffer #(
  parameter int CRC_KEY_WIDTH = 4,
  parameter int CRC_KEY_SIZE  = 16,
  parameter int CRC_WIDTH     = 32,
  parameter int DEPTH_LOG     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fprint_write,
  input  logic                     fprint_core,
  input  logic [CRC_KEY_WIDTH-1:0] fprint_task,
  input  logic [CRC_WIDTH-1:0]     fprint_data,
  input  logic                     checkin_write,
  input  logic                     checkin_core,
  input  logic [CRC_KEY_WIDTH-1:0] checkin_task,
  comp_fprint_buffer_if.slave      comp,
  output logic [CRC_KEY_SIZE-1:0]  fprints_ready,
  output logic [CRC_KEY_SIZE-1:0]  checkin,
  output logic [CRC_KEY_SIZE-1:0]  task_done,
  output logic [CRC_KEY_SIZE-1:0]  task_failed,
  output logic [1:0]               overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  typedef logic [DEPTH_LOG:0] ptr_t;
  localparam ptr_t PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

  logic [CRC_WIDTH-1:0] mem [2][CRC_KEY_SIZE][DEPTH];
  ptr_t head     [2][CRC_KEY_SIZE];
  ptr_t tail     [2][CRC_KEY_SIZE];
  ptr_t head_nxt [2][CRC_KEY_SIZE];
  ptr_t tail_nxt [2][CRC_KEY_SIZE];

  logic [CRC_KEY_SIZE-1:0] ck0, ck1;
  logic [CRC_KEY_SIZE-1:0] comp_sel, wr_sel, ci_sel;
  logic fp_go, tv_go, rt_go, sw_go;
  logic wr_full, wr_accept, rdy_set;
  ptr_t wr_head, wr_tail;

  // A handshake action fires only on the cycle whose edge raises the ack.
  assign fp_go = comp.comp_reset_fprint_ready & ~comp.reset_fprint_ack;
  assign tv_go = comp.comp_task_verified      & ~comp.fprint_reg_ack;
  assign rt_go = comp.comp_reset_task         & ~comp.reset_task_ack;
  assign sw_go = comp.comp_status_write       & ~comp.comp_status_ack;

  assign comp_sel = CRC_KEY_SIZE'(1) << comp.comp_task;
  assign wr_sel   = CRC_KEY_SIZE'(1) << fprint_task;
  assign ci_sel   = CRC_KEY_SIZE'(1) << checkin_task;

  assign wr_head   = head[fprint_core][fprint_task];
  assign wr_tail   = tail[fprint_core][fprint_task];
  assign wr_full   = (wr_head[DEPTH_LOG-1:0] == wr_tail[DEPTH_LOG-1:0]) &&
                     (wr_head[DEPTH_LOG] != wr_tail[DEPTH_LOG]);
  // A flush on the same edge frees the buffer, so that write is always kept.
  assign wr_accept = fprint_write & (~wr_full | (rt_go & (fprint_task == comp.comp_task)));

  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    for (int c = 0; c < 2; c++) begin
      if (rt_go)
        tail_nxt[c][comp.comp_task] = head[c][comp.comp_task];
      else if (comp.comp_increment_tail_pointer &&
               (tail[c][comp.comp_task] != head[c][comp.comp_task]))
        tail_nxt[c][comp.comp_task] = tail[c][comp.comp_task] + PTR_ONE;
    end
    if (wr_accept)
      head_nxt[fprint_core][fprint_task] = wr_head + PTR_ONE;
  end

  assign rdy_set = fprint_write &&
                   (head_nxt[0][fprint_task] != tail_nxt[0][fprint_task]) &&
                   (head_nxt[1][fprint_task] != tail_nxt[1][fprint_task]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        for (int t = 0; t < CRC_KEY_SIZE; t++) begin
          head[c][t] <= '0;
          tail[c][t] <= '0;
          for (int d = 0; d < DEPTH; d++)
            mem[c][t][d] <= '0;
        end
      end
      comp.reset_fprint_ack <= 1'b0;
      comp.fprint_reg_ack   <= 1'b0;
      comp.reset_task_ack   <= 1'b0;
      comp.comp_status_ack  <= 1'b0;
      fprints_ready         <= '0;
      ck0                   <= '0;
      ck1                   <= '0;
      task_done             <= '0;
      task_failed           <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      if (wr_accept)
        mem[fprint_core][fprint_task][wr_head[DEPTH_LOG-1:0]] <= fprint_data;

      comp.reset_fprint_ack <= fp_go;
      comp.fprint_reg_ack   <= tv_go;
      comp.reset_task_ack   <= rt_go;
      comp.comp_status_ack  <= sw_go;

      // Sets are OR-ed in after the clears so they win on a shared edge.
      fprints_ready <= (fprints_ready & ~(comp_sel & {CRC_KEY_SIZE{fp_go | rt_go}})) |
                       (wr_sel & {CRC_KEY_SIZE{rdy_set}});
      ck0 <= (ck0 & ~(comp_sel & {CRC_KEY_SIZE{tv_go | rt_go}})) |
             (ci_sel & {CRC_KEY_SIZE{checkin_write & ~checkin_core}});
      ck1 <= (ck1 & ~(comp_sel & {CRC_KEY_SIZE{tv_go | rt_go}})) |
             (ci_sel & {CRC_KEY_SIZE{checkin_write & checkin_core}});

      if (sw_go) begin
        task_done   <= task_done | comp_sel;
        task_failed <= (task_failed & ~comp_sel) |
                       (comp_sel & {CRC_KEY_SIZE{comp.comp_mismatch_detected}});
      end
    end
  end

  assign checkin = ck0 & ck1;

  assign comp.fprint0 = mem[0][comp.comp_task][tail[0][comp.comp_task][DEPTH_LOG-1:0]];
  assign comp.fprint1 = mem[1][comp.comp_task][tail[1][comp.comp_task][DEPTH_LOG-1:0]];
  assign comp.head0_matches_head1 = (head[0][comp.comp_task] == head[1][comp.comp_task]);
  assign comp.tail0_matches_head0 = (tail[0][comp.comp_task] == head[0][comp.comp_task]);
  assign comp.tail1_matches_head1 = (tail[1][comp.comp_task] == head[1][comp.comp_task]);

`ifdef COMP_BUF_OVERFLOW_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 2'b00;
    else if (fprint_write && !wr_accept)
      overflow[fprint_core] <= 1'b1;
  end
`else
  assign overflow = 2'b00;
`endif
endmodule

// File: tb/tb_comp_fprint_buffer.sv
// tb/tb_comp_fprint_buffer.sv - self-checking bench for comp_fprint_buffer: directed, table and random-vs-model
module tb_comp_fprint_buffer;
  localparam int KW = 4, KS = 16, CW = 32, DL = 3, DEPTH = 8;
`ifdef COMP_BUF_OVERFLOW_EN
  localparam logic [1:0] OVF_CORE0 = 2'b01;
`else
  localparam logic [1:0] OVF_CORE0 = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fprint_write, fprint_core, checkin_write, checkin_core;
  logic [KW-1:0] fprint_task, checkin_task;
  logic [CW-1:0] fprint_data;
  logic [KS-1:0] fprints_ready, checkin, task_done, task_failed;
  logic [1:0]    overflow;

  comp_fprint_buffer_if #(.CRC_KEY_WIDTH(KW), .CRC_WIDTH(CW)) cif ();

  comp_fprint_buffer #(.CRC_KEY_WIDTH(KW), .CRC_KEY_SIZE(KS), .CRC_WIDTH(CW), .DEPTH_LOG(DL)) dut (
    .clk(clk), .reset(reset),
    .fprint_write(fprint_write), .fprint_core(fprint_core), .fprint_task(fprint_task),
    .fprint_data(fprint_data), .checkin_write(checkin_write), .checkin_core(checkin_core),
    .checkin_task(checkin_task), .comp(cif), .fprints_ready(fprints_ready), .checkin(checkin),
    .task_done(task_done), .task_failed(task_failed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fprint_write = 0; fprint_core = 0; fprint_task = '0; fprint_data = '0;
    checkin_write = 0; checkin_core = 0; checkin_task = '0;
    cif.comp_task = '0; cif.comp_increment_tail_pointer = 0; cif.comp_reset_fprint_ready = 0;
    cif.comp_task_verified = 0; cif.comp_reset_task = 0; cif.comp_status_write = 0;
    cif.comp_mismatch_detected = 0;
  endtask

  task automatic wr(input logic c, input logic [KW-1:0] t, input logic [CW-1:0] d);
    fprint_write = 1; fprint_core = c; fprint_task = t; fprint_data = d;
    step();
    fprint_write = 0;
  endtask

  // ---------------- reference model: queues per (core, task) ----------------
  logic [31:0] mq [32][$];
  int          hc [32];
  logic [KS-1:0] m_rdy, m_ck0, m_ck1, m_done, m_failed;
  logic [1:0]    m_ovf;
  logic          m_ack_fp, m_ack_tv, m_ack_rt, m_ack_sw;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mq[i].delete(); hc[i] = 0; end
    m_rdy = '0; m_ck0 = '0; m_ck1 = '0; m_done = '0; m_failed = '0; m_ovf = '0;
    m_ack_fp = 0; m_ack_tv = 0; m_ack_rt = 0; m_ack_sw = 0;
  endtask

  task automatic model_update();
    bit go_fp = cif.comp_reset_fprint_ready && !m_ack_fp;
    bit go_tv = cif.comp_task_verified && !m_ack_tv;
    bit go_rt = cif.comp_reset_task && !m_ack_rt;
    bit go_sw = cif.comp_status_write && !m_ack_sw;
    int ct = int'(cif.comp_task);
    int ft = int'(fprint_task);
    int wi = int'(fprint_core) * 16 + ft;
    bit was_full = (mq[wi].size() == DEPTH);
    if (go_rt) begin
      mq[ct].delete(); mq[16 + ct].delete();
    end else if (cif.comp_increment_tail_pointer) begin
      for (int c = 0; c < 2; c++)
        if (mq[c * 16 + ct].size() > 0) void'(mq[c * 16 + ct].pop_front());
    end
    if (fprint_write) begin
      if (was_full && !(go_rt && ft == ct)) begin
`ifdef COMP_BUF_OVERFLOW_EN
        m_ovf[fprint_core] = 1'b1;
`endif
      end else begin
        mq[wi].push_back(fprint_data);
        hc[wi] = (hc[wi] + 1) % 16;
      end
    end
    if (go_fp || go_rt) m_rdy[ct] = 1'b0;
    if (fprint_write && mq[ft].size() > 0 && mq[16 + ft].size() > 0) m_rdy[ft] = 1'b1;
    if (go_tv || go_rt) begin m_ck0[ct] = 1'b0; m_ck1[ct] = 1'b0; end
    if (checkin_write) begin
      if (checkin_core) m_ck1[checkin_task] = 1'b1;
      else              m_ck0[checkin_task] = 1'b1;
    end
    if (go_sw) begin m_done[ct] = 1'b1; m_failed[ct] = cif.comp_mismatch_detected; end
    m_ack_fp = go_fp; m_ack_tv = go_tv; m_ack_rt = go_rt; m_ack_sw = go_sw;
  endtask

  task automatic model_compare();
    int ct = int'(cif.comp_task);
    chk("rnd_ack_fp", 32'(cif.reset_fprint_ack), 32'(m_ack_fp));
    chk("rnd_ack_tv", 32'(cif.fprint_reg_ack), 32'(m_ack_tv));
    chk("rnd_ack_rt", 32'(cif.reset_task_ack), 32'(m_ack_rt));
    chk("rnd_ack_sw", 32'(cif.comp_status_ack), 32'(m_ack_sw));
    chk("rnd_ready", 32'(fprints_ready), 32'(m_rdy));
    chk("rnd_checkin", 32'(checkin), 32'(m_ck0 & m_ck1));
    chk("rnd_done", 32'(task_done), 32'(m_done));
    chk("rnd_failed", 32'(task_failed), 32'(m_failed));
    chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
    chk("rnd_h0h1", 32'(cif.head0_matches_head1), 32'(hc[ct] == hc[16 + ct]));
    chk("rnd_empty0", 32'(cif.tail0_matches_head0), 32'(mq[ct].size() == 0));
    chk("rnd_empty1", 32'(cif.tail1_matches_head1), 32'(mq[16 + ct].size() == 0));
    if (mq[ct].size() > 0)      chk("rnd_fprint0", cif.fprint0, mq[ct][0]);
    if (mq[16 + ct].size() > 0) chk("rnd_fprint1", cif.fprint1, mq[16 + ct][0]);
  endtask

  // ---------------- table records ----------------
  typedef struct {
    logic ci_w; logic ci_c; logic [KW-1:0] ci_t; logic tv; logic [KW-1:0] ct;
    logic [KS-1:0] exp_ck; logic exp_ack;
  } ck_vec_t;
  typedef struct {
    logic [KW-1:0] tsk; logic mm; logic [KS-1:0] exp_done; logic [KS-1:0] exp_failed;
  } sw_vec_t;

  ck_vec_t ck_tab [8];
  sw_vec_t sw_tab [4];
  logic    hs_exp [4];

  initial begin
    ck_tab[0] = '{1'b1, 1'b0, 4'd4, 1'b0, 4'd4, 16'h0000, 1'b0};
    ck_tab[1] = '{1'b1, 1'b1, 4'd4, 1'b0, 4'd4, 16'h0010, 1'b0};
    ck_tab[2] = '{1'b1, 1'b1, 4'd6, 1'b0, 4'd4, 16'h0010, 1'b0};
    ck_tab[3] = '{1'b1, 1'b0, 4'd6, 1'b0, 4'd4, 16'h0050, 1'b0};
    ck_tab[4] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 16'h0040, 1'b1};
    ck_tab[5] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd6, 16'h0040, 1'b0};
    ck_tab[6] = '{1'b1, 1'b0, 4'd6, 1'b1, 4'd6, 16'h0000, 1'b1};
    ck_tab[7] = '{1'b1, 1'b1, 4'd6, 1'b0, 4'd6, 16'h0040, 1'b0};
    sw_tab[0] = '{4'd2,  1'b1, 16'h0004, 16'h0004};
    sw_tab[1] = '{4'd9,  1'b0, 16'h0204, 16'h0004};
    sw_tab[2] = '{4'd2,  1'b0, 16'h0204, 16'h0000};
    sw_tab[3] = '{4'd15, 1'b1, 16'h8204, 16'h8000};
    hs_exp[0] = 1; hs_exp[1] = 0; hs_exp[2] = 1; hs_exp[3] = 0;

    idle();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acks", 32'({cif.reset_fprint_ack, cif.fprint_reg_ack, cif.reset_task_ack, cif.comp_status_ack}), 0);
    chk("rst_ready", 32'(fprints_ready), 0);
    chk("rst_checkin", 32'(checkin), 0);
    chk("rst_done_failed", {task_done, task_failed}, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_fprint0", cif.fprint0, 0);
    chk("rst_fprint1", cif.fprint1, 0);
    reset = 1;
    step();

    // Pair on task 3, then pop it.
    cif.comp_task = 4'd3;
    wr(1'b0, 4'd3, 32'hA5A5_0001);
    chk("t3_ready_one_core", 32'(fprints_ready[3]), 0);
    wr(1'b1, 4'd3, 32'hA5A5_0001);
    chk("t3_ready", 32'(fprints_ready[3]), 1);
    chk("t3_fprint0", cif.fprint0, 32'hA5A5_0001);
    chk("t3_fprint1", cif.fprint1, 32'hA5A5_0001);
    chk("t3_h0h1", 32'(cif.head0_matches_head1), 1);
    chk("t3_empty_flags", 32'({cif.tail0_matches_head0, cif.tail1_matches_head1}), 0);
    cif.comp_increment_tail_pointer = 1;
    step();
    cif.comp_increment_tail_pointer = 0;
    chk("t3_empty_after_inc", 32'({cif.tail0_matches_head0, cif.tail1_matches_head1}), 32'h3);

    // Held fprint-ready reset request: ack pulses, gap, pulse.
    for (int i = 0; i < 4; i++) begin
      cif.comp_reset_fprint_ready = (i < 3);
      step();
      chk("hs_fp_ack", 32'(cif.reset_fprint_ack), 32'(hs_exp[i]));
    end
    chk("t3_ready_cleared", 32'(fprints_ready[3]), 0);

    // Fill task 5 on core 0 past capacity.
    cif.comp_task = 4'd5;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("t5_no_ovf_yet", 32'(overflow), 0);
      wr(1'b0, 4'd5, 32'h5500_0000 + 32'(i));
    end
    chk("t5_overflow", 32'(overflow), 32'(OVF_CORE0));
    chk("t5_h0h1", 32'(cif.head0_matches_head1), 0);
    chk("t5_not_empty", 32'(cif.tail0_matches_head0), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain", cif.fprint0, 32'h5500_0000 + 32'(i));
      cif.comp_increment_tail_pointer = 1;
      step();
      cif.comp_increment_tail_pointer = 0;
    end
    chk("t5_empty", 32'(cif.tail0_matches_head0), 1);

    // Flush task 7.
    wr(1'b0, 4'd7, 32'h7000_0000);
    wr(1'b0, 4'd7, 32'h7000_0001);
    wr(1'b0, 4'd7, 32'h7000_0002);
    wr(1'b1, 4'd7, 32'h7100_0000);
    cif.comp_task = 4'd7;
    chk("t7_ready", 32'(fprints_ready[7]), 1);
    cif.comp_reset_task = 1;
    step();
    chk("t7_ack", 32'(cif.reset_task_ack), 1);
    chk("t7_empty", 32'({cif.tail0_matches_head0, cif.tail1_matches_head1}), 32'h3);
    chk("t7_ready_cleared", 32'(fprints_ready[7]), 0);
    cif.comp_reset_task = 0;
    step();
    chk("t7_ack_low", 32'(cif.reset_task_ack), 0);

    // Checkin / verify table, one row per cycle.
    foreach (ck_tab[i]) begin
      checkin_write = ck_tab[i].ci_w; checkin_core = ck_tab[i].ci_c; checkin_task = ck_tab[i].ci_t;
      cif.comp_task_verified = ck_tab[i].tv; cif.comp_task = ck_tab[i].ct;
      step();
      chk("tab_checkin", 32'(checkin), 32'(ck_tab[i].exp_ck));
      chk("tab_verify_ack", 32'(cif.fprint_reg_ack), 32'(ck_tab[i].exp_ack));
    end
    idle();

    // Status write table.
    foreach (sw_tab[i]) begin
      cif.comp_task = sw_tab[i].tsk; cif.comp_mismatch_detected = sw_tab[i].mm;
      cif.comp_status_write = 1;
      step();
      chk("tab_status_ack", 32'(cif.comp_status_ack), 1);
      chk("tab_done", 32'(task_done), 32'(sw_tab[i].exp_done));
      chk("tab_failed", 32'(task_failed), 32'(sw_tab[i].exp_failed));
      cif.comp_status_write = 0; cif.comp_mismatch_detected = 0;
      step();
      chk("tab_status_ack_low", 32'(cif.comp_status_ack), 0);
    end

    // Randomized run against the queue model, from a fresh reset.
    idle();
    reset = 0;
    step();
    model_reset();
    model_compare();
    reset = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      fprint_write  = ($urandom_range(0, 9) < 6);
      fprint_core   = 1'($urandom_range(0, 1));
      fprint_task   = 4'($urandom_range(0, 3));
      fprint_data   = $urandom;
      checkin_write = ($urandom_range(0, 4) == 0);
      checkin_core  = 1'($urandom_range(0, 1));
      checkin_task  = 4'($urandom_range(0, 3));
      cif.comp_task = 4'($urandom_range(0, 3));
      cif.comp_reset_task = ($urandom_range(0, 11) == 0);
      cif.comp_increment_tail_pointer = !cif.comp_reset_task && ($urandom_range(0, 3) == 0);
      cif.comp_reset_fprint_ready = ($urandom_range(0, 9) < 3);
      cif.comp_task_verified      = ($urandom_range(0, 9) < 3);
      cif.comp_status_write       = ($urandom_range(0, 9) < 3);
      cif.comp_mismatch_detected  = 1'($urandom_range(0, 1));
      model_update();
      step();
      model_compare();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
